voice_allocator: RTL and testbench

- Polyphony controller for the keyboard's oscillator bank.
- Accepts note-on/note-off events decoded from the PIC's SPI stream. Assigns each note to one of NUM_VOICES oscillator voices and drives each voice's period and gate.
- Replaces the direct prd1/prd2/prd3 wiring: the square/sawtooth/triangle/sine instances take their periods from this block.
- Steals the least-recently-allocated voice when all voices are busy.

---
 rtl/voice_allocator.sv | 205 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller for the oscillator bank.
// Accepts note-on/note-off events (valid/ready), assigns notes to voices,
// drives per-voice period/key/gate, and steals the least-recently-allocated
// voice when every voice is busy.
//
// Handshake: an event transfers on a rising edge where ev_valid && ev_ready.
// ev_ready is high only in IDLE (and never while reset is high); the source
// must hold ev_on/ev_key/ev_period stable with ev_valid until that edge.
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int PRD_W      = 33,
    parameter int KEY_W      = 6,
    parameter int RANK_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [KEY_W-1:0]            ev_key,
    input  logic [PRD_W-1:0]            ev_period,
    output logic [NUM_VOICES*PRD_W-1:0] voice_prd,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       gate,
    output logic                        steal,
    output logic                        drop
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic {IDLE, PROCESS} state_t;

    state_t state, state_nxt;

    // Latched event
    logic              lat_on;
    logic [KEY_W-1:0]  lat_key;
    logic [PRD_W-1:0]  lat_prd;

    // Per-voice state; rank 0 is the newest active voice
    logic [PRD_W-1:0]  prd_r  [NUM_VOICES];
    logic [PRD_W-1:0]  prd_n  [NUM_VOICES];
    logic [KEY_W-1:0]  key_r  [NUM_VOICES];
    logic [KEY_W-1:0]  key_n  [NUM_VOICES];
    logic [RANK_W-1:0] rank_r [NUM_VOICES];
    logic [RANK_W-1:0] rank_n [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_r, gate_n;
    logic steal_r, steal_n, drop_r, drop_n;

    // Voice search results
    logic             match_hit, free_hit;
    logic [IDX_W-1:0] match_idx, free_idx, lru_idx;

    // Apply decode
    logic              do_alloc, do_free, was_free;
    logic [IDX_W-1:0]  tgt;
    logic [RANK_W-1:0] tgt_rank;

    logic accept;

    assign ev_ready = (state == IDLE) && !reset;
    assign accept   = ev_valid && ev_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: one accept cycle, one apply cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = PROCESS;
            PROCESS: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the accepted event for the PROCESS cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_on  <= 1'b0;
            lat_key <= '0;
            lat_prd <= '0;
        end else if (accept) begin
            lat_on  <= ev_on;
            lat_key <= ev_key;
            lat_prd <= ev_period;
        end
    end

    // Find matching active voice, lowest free voice and the oldest active voice
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        lru_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_r[i] && (key_r[i] == lat_key)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!gate_r[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (gate_r[i] && (rank_r[i] == RANK_W'(NUM_VOICES - 1)))
                lru_idx = IDX_W'(i);
        end
    end

    // Decide what the latched event does and compute next voice state
    always_comb begin
        do_alloc = 1'b0;
        do_free  = 1'b0;
        was_free = 1'b0;
        tgt      = '0;
        steal_n  = 1'b0;
        drop_n   = 1'b0;
        gate_n   = gate_r;
        for (int i = 0; i < NUM_VOICES; i++) begin
            prd_n[i]  = prd_r[i];
            key_n[i]  = key_r[i];
            rank_n[i] = rank_r[i];
        end

        if (state == PROCESS) begin
            if (lat_on) begin
                if (lat_prd == '0) begin
                    drop_n = 1'b1;
                end else begin
                    do_alloc = 1'b1;
                    if (match_hit) begin
                        tgt = match_idx;
                    end else if (free_hit) begin
                        tgt      = free_idx;
                        was_free = 1'b1;
                    end else begin
                        tgt     = lru_idx;
                        steal_n = 1'b1;
                    end
                end
            end else if (match_hit) begin
                do_free = 1'b1;
                tgt     = match_idx;
            end
        end

        tgt_rank = rank_r[tgt];

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (do_alloc) begin
                if (IDX_W'(i) == tgt) begin
                    rank_n[i] = '0;
                    gate_n[i] = 1'b1;
                    key_n[i]  = lat_key;
                    prd_n[i]  = lat_prd;
                end else if (gate_r[i] && (was_free || (rank_r[i] < tgt_rank))) begin
                    rank_n[i] = rank_r[i] + RANK_W'(1);
                end
            end else if (do_free) begin
                if (IDX_W'(i) == tgt) begin
                    gate_n[i] = 1'b0;
                end else if (gate_r[i] && (rank_r[i] > tgt_rank)) begin
                    rank_n[i] = rank_r[i] - RANK_W'(1);
                end
            end
        end
    end

    // Voice state and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_r  <= '0;
            steal_r <= 1'b0;
            drop_r  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                prd_r[i]  <= '0;
                key_r[i]  <= '0;
                rank_r[i] <= '0;
            end
        end else begin
            gate_r  <= gate_n;
            steal_r <= steal_n;
            drop_r  <= drop_n;
            for (int i = 0; i < NUM_VOICES; i++) begin
                prd_r[i]  <= prd_n[i];
                key_r[i]  <= key_n[i];
                rank_r[i] <= rank_n[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_prd[g*PRD_W +: PRD_W] = prd_r[g];
        assign voice_key[g*KEY_W +: KEY_W] = key_r[g];
    end

    assign gate  = gate_r;
    assign steal = steal_r;
    assign drop  = drop_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: scenario tasks compared against a
// queue-based LRU voice model.
module tb_voice_allocator;

    localparam int N  = 3;
    localparam int PW = 33;
    localparam int KW = 6;

    logic            clk;
    logic            reset;
    logic            ev_valid;
    logic            ev_ready;
    logic            ev_on;
    logic [KW-1:0]   ev_key;
    logic [PW-1:0]   ev_period;
    logic [N*PW-1:0] voice_prd;
    logic [N*KW-1:0] voice_key;
    logic [N-1:0]    gate;
    logic            steal;
    logic            drop;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.NUM_VOICES(N), .PRD_W(PW), .KEY_W(KW), .RANK_W(2)) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_key(ev_key), .ev_period(ev_period),
        .voice_prd(voice_prd), .voice_key(voice_key), .gate(gate),
        .steal(steal), .drop(drop)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Each voice has key/period/active; lru holds active voices, newest first.
    logic [KW-1:0] m_key [N];
    logic [PW-1:0] m_prd [N];
    logic          m_act [N];
    int            lru[$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_key[i] = '0; m_prd[i] = '0; m_act[i] = 1'b0;
        end
        lru.delete();
    endfunction

    function automatic void lru_remove(input int v);
        for (int j = 0; j < lru.size(); j++)
            if (lru[j] == v) begin lru.delete(j); break; end
    endfunction

    function automatic void model_event(input logic on, input logic [KW-1:0] key,
                                        input logic [PW-1:0] prd,
                                        output logic s, output logic d);
        int v = -1;
        s = 1'b0; d = 1'b0;
        for (int i = 0; i < N; i++) if (m_act[i] && m_key[i] == key) v = i;
        if (on) begin
            if (prd == 0) begin
                d = 1'b1;
                return;
            end
            if (v < 0) for (int i = N - 1; i >= 0; i--) if (!m_act[i]) v = i;
            if (v < 0) begin v = lru[lru.size()-1]; s = 1'b1; end
            lru_remove(v);
            lru.push_front(v);
            m_act[v] = 1'b1; m_key[v] = key; m_prd[v] = prd;
        end else if (v >= 0) begin
            m_act[v] = 1'b0;
            lru_remove(v);
        end
    endfunction

    function automatic logic [N-1:0] exp_gate();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_act[i];
        return r;
    endfunction

    function automatic logic [N*PW-1:0] exp_prd();
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = m_prd[i];
        return r;
    endfunction

    function automatic logic [N*KW-1:0] exp_key();
        logic [N*KW-1:0] r;
        for (int i = 0; i < N; i++) r[i*KW +: KW] = m_key[i];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ev_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one event through the handshake and the PROCESS cycle; returns
    // ev_ready during PROCESS, ev_ready after it, and the steal/drop pulses.
    task automatic drive_event(input logic on, input logic [KW-1:0] key,
                               input logic [PW-1:0] prd,
                               output logic rdy_proc, output logic rdy_after,
                               output logic st, output logic dr);
        logic es, ed;
        int waited = 0;
        rdy_proc = 1'bx; rdy_after = 1'bx; st = 1'bx; dr = 1'bx;
        @(negedge clk);
        ev_valid = 1'b1; ev_on = on; ev_key = key; ev_period = prd;
        while (!ev_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ev_ready) begin
            checks++; errors++;
            $display("FAIL ev_ready_timeout: ev_ready=%b after %0d cycles, required 1", ev_ready, waited);
            ev_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ev_valid  = 1'b0;
        rdy_proc  = ev_ready;
        @(negedge clk);
        rdy_after = ev_ready;
        st = steal;
        dr = drop;
        model_event(on, key, prd, es, ed);
    endtask

    // Expected pulses come from the model call inside drive_event; keep a copy.
    logic x_s, x_d;
    task automatic drive_and_predict(input logic on, input logic [KW-1:0] key,
                                     input logic [PW-1:0] prd,
                                     output logic rp, output logic ra,
                                     output logic st, output logic dr);
        logic [KW-1:0] k0 [N]; logic [PW-1:0] p0 [N]; logic a0 [N]; int l0[$];
        k0 = m_key; p0 = m_prd; a0 = m_act; l0 = lru;
        model_event(on, key, prd, x_s, x_d);
        m_key = k0; m_prd = p0; m_act = a0; lru = l0;
        drive_event(on, key, prd, rp, ra, st, dr);
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_key = 6'd3; ev_period = 33'd77;
        repeat (2) @(negedge clk);
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ev_ready); end
        checks++; if (gate !== '0) begin errors++; $display("FAIL reset_gate: got %b required 0", gate); end
        checks++; if (voice_prd !== '0) begin errors++; $display("FAIL reset_prd: got %h required 0", voice_prd); end
        checks++; if (voice_key !== '0) begin errors++; $display("FAIL reset_key: got %h required 0", voice_key); end
        checks++; if ({steal, drop} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b required 00", {steal, drop}); end
        ev_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", ev_ready); end
    endtask

    task automatic test_single_note();
        logic rp, ra, st, dr;
        do_reset();
        drive_and_predict(1'b1, 6'd5, 33'd1000, rp, ra, st, dr);
        checks++; if (rp !== 1'b0) begin errors++; $display("FAIL single_ready_proc: got %b required 0", rp); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %b required 1", ra); end
        checks++; if (gate !== 3'b001) begin errors++; $display("FAIL single_gate: got %b required 001", gate); end
        checks++; if (voice_prd[0 +: PW] !== 33'd1000) begin errors++; $display("FAIL single_prd0: got %0d required 1000", voice_prd[0 +: PW]); end
        checks++; if (voice_key[0 +: KW] !== 6'd5) begin errors++; $display("FAIL single_key0: got %0d required 5", voice_key[0 +: KW]); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL single_steal: got %b required 0", st); end
    endtask

    task automatic fill_123();
        logic rp, ra, st, dr;
        do_reset();
        drive_and_predict(1'b1, 6'd1, 33'd100, rp, ra, st, dr);
        drive_and_predict(1'b1, 6'd2, 33'd200, rp, ra, st, dr);
        drive_and_predict(1'b1, 6'd3, 33'd300, rp, ra, st, dr);
    endtask

    task automatic test_steal();
        logic rp, ra, st, dr;
        fill_123();
        checks++; if (gate !== 3'b111) begin errors++; $display("FAIL fill_gate: got %b required 111", gate); end
        drive_and_predict(1'b1, 6'd4, 33'd400, rp, ra, st, dr);
        checks++; if (voice_key[0 +: KW] !== 6'd4) begin errors++; $display("FAIL steal_key0: got %0d required 4", voice_key[0 +: KW]); end
        checks++; if (voice_prd[0 +: PW] !== 33'd400) begin errors++; $display("FAIL steal_prd0: got %0d required 400", voice_prd[0 +: PW]); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL steal_pulse: got %b required 1", st); end
        checks++; if (dr !== 1'b0) begin errors++; $display("FAIL steal_drop: got %b required 0", dr); end
        checks++; if (gate !== 3'b111) begin errors++; $display("FAIL steal_gate: got %b required 111", gate); end
        @(negedge clk);
        checks++; if (steal !== 1'b0) begin errors++; $display("FAIL steal_one_cycle: got %b required 0", steal); end
    endtask

    task automatic test_retrigger();
        logic rp, ra, st, dr;
        fill_123();
        drive_and_predict(1'b1, 6'd1, 33'd500, rp, ra, st, dr);
        checks++; if (voice_prd[0 +: PW] !== 33'd500) begin errors++; $display("FAIL retrig_prd0: got %0d required 500", voice_prd[0 +: PW]); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL retrig_steal: got %b required 0", st); end
        drive_and_predict(1'b1, 6'd9, 33'd900, rp, ra, st, dr);
        checks++; if (voice_key[KW +: KW] !== 6'd9) begin errors++; $display("FAIL retrig_victim_key1: got %0d required 9", voice_key[KW +: KW]); end
        checks++; if (voice_key !== exp_key()) begin errors++; $display("FAIL retrig_keys: got %h required %h", voice_key, exp_key()); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL retrig_victim_steal: got %b required 1", st); end
    endtask

    task automatic test_note_off();
        logic rp, ra, st, dr;
        fill_123();
        drive_and_predict(1'b0, 6'd2, 33'd0, rp, ra, st, dr);
        checks++; if (gate !== 3'b101) begin errors++; $display("FAIL off_gate: got %b required 101", gate); end
        checks++; if (voice_prd[PW +: PW] !== 33'd200) begin errors++; $display("FAIL off_prd_held: got %0d required 200", voice_prd[PW +: PW]); end
        checks++; if (voice_key[KW +: KW] !== 6'd2) begin errors++; $display("FAIL off_key_held: got %0d required 2", voice_key[KW +: KW]); end
        drive_and_predict(1'b1, 6'd7, 33'd700, rp, ra, st, dr);
        checks++; if (gate !== 3'b111) begin errors++; $display("FAIL off_realloc_gate: got %b required 111", gate); end
        checks++; if (voice_key[KW +: KW] !== 6'd7) begin errors++; $display("FAIL off_realloc_key1: got %0d required 7", voice_key[KW +: KW]); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL off_realloc_steal: got %b required 0", st); end
        drive_and_predict(1'b0, 6'd30, 33'd0, rp, ra, st, dr);
        checks++; if ({gate, voice_key, voice_prd} !== {exp_gate(), exp_key(), exp_prd()}) begin
            errors++; $display("FAIL off_nomatch_state: gate %b key %h prd %h, required gate %b key %h prd %h",
                               gate, voice_key, voice_prd, exp_gate(), exp_key(), exp_prd());
        end
        checks++; if ({st, dr} !== 2'b00) begin errors++; $display("FAIL off_nomatch_pulses: got %b required 00", {st, dr}); end
    endtask

    task automatic test_drop();
        logic rp, ra, st, dr;
        logic [N-1:0] g0; logic [N*PW-1:0] p0; logic [N*KW-1:0] k0;
        fill_123();
        g0 = exp_gate(); p0 = exp_prd(); k0 = exp_key();
        drive_and_predict(1'b1, 6'd8, 33'd0, rp, ra, st, dr);
        checks++; if (dr !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b required 1", dr); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL drop_steal: got %b required 0", st); end
        checks++; if ({gate, voice_prd, voice_key} !== {g0, p0, k0}) begin
            errors++; $display("FAIL drop_state: gate %b prd %h key %h, required gate %b prd %h key %h",
                               gate, voice_prd, voice_key, g0, p0, k0);
        end
        @(negedge clk);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b required 0", drop); end
    endtask

    task automatic test_reset_in_process();
        fill_123();
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_key = 6'd4; ev_period = 33'd400;
        @(negedge clk);
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rip_in_process: ev_ready %b required 0", ev_ready); end
        ev_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL rip_ready_in_reset: got %b required 0", ev_ready); end
        checks++; if (gate !== 3'b000) begin errors++; $display("FAIL rip_gate: got %b required 000", gate); end
        checks++; if (voice_prd !== '0) begin errors++; $display("FAIL rip_prd: got %h required 0", voice_prd); end
        checks++; if ({steal, drop} !== 2'b00) begin errors++; $display("FAIL rip_pulses_in_reset: got %b required 00", {steal, drop}); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL rip_ready_after: got %b required 1", ev_ready); end
        @(negedge clk);
        checks++; if ({steal, drop, gate} !== 5'b00000) begin errors++; $display("FAIL rip_after_state: steal/drop/gate %b required 00000", {steal, drop, gate}); end
    endtask

    task automatic test_random();
        logic rp, ra, st, dr;
        logic on; logic [KW-1:0] key; logic [PW-1:0] prd;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            on  = ($urandom_range(0, 2) != 0);
            key = KW'($urandom_range(0, 6));
            prd = ($urandom_range(0, 9) == 0) ? '0 : PW'($urandom_range(1, 100000));
            drive_and_predict(on, key, prd, rp, ra, st, dr);
            checks++; if (gate !== exp_gate()) begin errors++; $display("FAIL rand_gate[%0d]: got %b required %b", n, gate, exp_gate()); end
            checks++; if (voice_key !== exp_key()) begin errors++; $display("FAIL rand_key[%0d]: got %h required %h", n, voice_key, exp_key()); end
            checks++; if (voice_prd !== exp_prd()) begin errors++; $display("FAIL rand_prd[%0d]: got %h required %h", n, voice_prd, exp_prd()); end
            checks++; if ({st, dr} !== {x_s, x_d}) begin errors++; $display("FAIL rand_pulses[%0d]: got %b required %b", n, {st, dr}, {x_s, x_d}); end
            checks++; if ({rp, ra} !== 2'b01) begin errors++; $display("FAIL rand_ready[%0d]: got %b required 01", n, {rp, ra}); end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_key = '0; ev_period = '0;
        model_reset();
        test_reset();
        test_single_note();
        test_steal();
        test_retrigger();
        test_note_off();
        test_drop();
        test_reset_in_process();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
